// File: rtl/mips_fetch.sv
// mips_fetch
// Instruction-fetch and PC-sequencing stage. Owns the PC and the held
// instruction register (IR), fetches over a variable-latency imem handshake,
// exposes opcode/func to the control decoder and selects the next PC from the
// decoder's branch/bne/jump/jr outputs and the ALU zero flag.
//
// Ports:
//   clk, reset            - rising-edge clock, synchronous active-high reset
//   imem_req/addr         - fetch request and address (address == pc_out)
//   imem_ready/rdata      - fetch completion and returned instruction word
//   instr_out/op_out/func_out - held IR and its decoder fields
//   pc_out/pc_plus4_out   - PC of the held instruction and PC + 4
//   instr_valid_out       - IR executing this cycle (commit qualifier)
//   stall_in              - hold the current instruction in EXEC
//   branch_in/bne_in/jump_in/jr_in/zero_in/rs_data_in - next-PC controls
//   misalign_out          - sticky flag: jr to a non-word-aligned target
module mips_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [5:0]  op_out,
  output logic [5:0]  func_out,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4_out,
  output logic        instr_valid_out,
  input  logic        stall_in,
  input  logic        branch_in,
  input  logic        bne_in,
  input  logic        jump_in,
  input  logic        jr_in,
  input  logic        zero_in,
  input  logic [31:0] rs_data_in,
  output logic        misalign_out
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } state_t;

  state_t      state, state_nx;
  logic [31:0] pc, pc_nx;
  logic [31:0] ir, ir_nx;
  logic        misalign, misalign_nx;

  logic [31:0] pc4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic        take_br;

  assign pc4       = pc + 32'd4;
  assign br_target = pc4 + {{14{ir[15]}}, ir[15:0], 2'b00};
  assign j_target  = {pc4[31:28], ir[25:0], 2'b00};
  assign take_br   = (branch_in & zero_in) | (bne_in & ~zero_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_RST;
      pc       <= RESET_PC;
      ir       <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      ir       <= ir_nx;
      misalign <= misalign_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    ir_nx       = ir;
    misalign_nx = misalign;
    case (state)
      ST_RST:  state_nx = ST_REQ;
      ST_REQ: begin
        if (imem_ready) begin
          ir_nx    = imem_rdata;
          state_nx = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (!stall_in) begin
          state_nx = ST_REQ;
          if (jr_in) begin
            // Low bits are cleared unconditionally; for an aligned target
            // this is the target itself.
            pc_nx = {rs_data_in[31:2], 2'b00};
            if (rs_data_in[1:0] != 2'b00) begin
              misalign_nx = 1'b1;
              state_nx    = ST_HALT;
            end
          end else if (jump_in) begin
            pc_nx = j_target;
          end else if (take_br) begin
            pc_nx = br_target;
          end else begin
            pc_nx = pc4;
          end
        end
      end
      ST_HALT: state_nx = ST_HALT;
      default: state_nx = ST_RST;
    endcase
  end

  assign imem_req        = (state == ST_REQ);
  assign instr_valid_out = (state == ST_EXEC);
  assign imem_addr       = pc;
  assign pc_out          = pc;
  assign pc_plus4_out    = pc4;
  assign instr_out       = ir;
  assign op_out          = ir[31:26];
  assign func_out        = ir[5:0];
  assign misalign_out    = misalign;

endmodule
